// File: rtl/ovf_accum_pkg.sv
// Shared types and constants for the overflow-tracking accumulator.
// Holds the overflow-direction enum and the saturation limits, which are
// constant functions of the data width.
package ovf_accum_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } ovf_dir_t;

  // Largest positive two's-complement value of width w (0111..1), in 64 bits.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of width w (1000..0); only the low w bits are meaningful.
  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/ovf_accum_if.sv
// Handshake bundle for ovf_accum.
//   in_valid/in_ready/in_data/in_clr : input side (producer -> accumulator)
//   out_valid/out_ready/acc_out/of_* : result side (accumulator -> consumer)
// slave  : the accumulator's view.
// master : the environment's view (producer and consumer together).
interface ovf_accum_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc_out;
  logic             of_pulse;
  logic             of_sticky;
  logic [CNT_W-1:0] of_count;

  modport slave (
    input  in_valid, in_data, in_clr, out_ready,
    output in_ready, out_valid, acc_out, of_pulse, of_sticky, of_count
  );

  modport master (
    output in_valid, in_data, in_clr, out_ready,
    input  in_ready, out_valid, acc_out, of_pulse, of_sticky, of_count
  );
endinterface

// File: rtl/ovf_add.sv
// Combinational signed adder with overflow-direction detect.
//   a, b    : WIDTH-bit two's-complement operands
//   sum     : wrapped WIDTH-bit result
//   ovf_dir : NONE, POS (positive overflow) or NEG (negative overflow)
import ovf_accum_pkg::*;

module ovf_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output ovf_dir_t         ovf_dir
);

  logic [WIDTH:0] ext;

  // Sign-extended WIDTH+1 bit sum: the top two bits differ exactly when the
  // carry into the MSB differs from the carry out of it; the top bit then
  // carries the true sign, which gives the direction.
  always_comb begin
    ext     = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    sum     = ext[WIDTH-1:0];
    ovf_dir = NONE;
    if (ext[WIDTH] != ext[WIDTH-1]) begin
      ovf_dir = ext[WIDTH] ? NEG : POS;
    end
  end

endmodule

// File: rtl/ovf_accum.sv
// Signed accumulator with overflow flag, sticky flag and saturating counter.
// One result register with pass-through backpressure (in_ready =
// !out_valid | out_ready); latency 1 cycle from acceptance to acc_out.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ovf_accum_if.slave (handshake, data, clear, result and flags)
// Build option: define OVF_ACCUM_SAT_EN to clamp the accumulator on overflow
// instead of wrapping; overflow is flagged and counted the same either way.
import ovf_accum_pkg::*;

module ovf_accum #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  ovf_accum_if.slave     bus
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_q;
  logic             valid_q;
  logic             pulse_q;
  logic             sticky_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc_next;
  ovf_dir_t         dir;
  logic             ovf;
  logic             ready;
  logic             accept;

  ovf_add #(.WIDTH(WIDTH)) u_add (
    .a       (acc),
    .b       (bus.in_data),
    .sum     (sum),
    .ovf_dir (dir)
  );

  assign ready  = !valid_q || bus.out_ready;
  assign accept = bus.in_valid && ready;
  assign ovf    = (dir != NONE);

`ifdef OVF_ACCUM_SAT_EN
  localparam logic [63:0]      MAX64   = sat_max(WIDTH);
  localparam logic [63:0]      MIN64   = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SAT_MAX = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_MIN = MIN64[WIDTH-1:0];

  always_comb begin
    acc_next = sum;
    case (dir)
      POS:     acc_next = SAT_MAX;
      NEG:     acc_next = SAT_MIN;
      default: acc_next = sum;
    endcase
  end
`else
  always_comb begin
    acc_next = sum;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      if (bus.in_clr) begin
        // Clear with acceptance: the new input starts a fresh accumulation.
        acc      <= bus.in_data;
        acc_q    <= bus.in_data;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
        count_q  <= '0;
      end else begin
        acc      <= acc_next;
        acc_q    <= acc_next;
        pulse_q  <= ovf;
        sticky_q <= sticky_q | ovf;
        if (ovf && (count_q != '1)) begin
          count_q <= count_q + 1'b1;
        end
      end
    end else begin
      if (bus.in_clr) begin
        acc      <= '0;
        sticky_q <= 1'b0;
        count_q  <= '0;
      end
      if (bus.out_ready) begin
        valid_q <= 1'b0;
        pulse_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.of_pulse  = pulse_q;
  assign bus.of_sticky = sticky_q;
  assign bus.of_count  = count_q;

endmodule

// File: tb/tb_ovf_accum.sv
module tb_ovf_accum;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ovf_accum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  ovf_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int acc;
    bit pulse;
  } exp_t;
  exp_t sb[$];

  // Reference model state: integer-valued accumulator and flags.
  int m_acc    = 0;
  bit m_ov     = 0;
  bit m_sticky = 0;
  int m_count  = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int add_result(input int a, input int b, output bit o);
    int s;
    s = a + b;
    o = (s > 127) || (s < -128);
`ifdef OVF_ACCUM_SAT_EN
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
`else
    return ((s + 384) % 256) - 128;
`endif
  endfunction

  // One clock: drive inputs after the edge, check state and update the model
  // at the falling edge (the model then describes the state after the next edge).
  task automatic step(input bit v, input int d, input bit c, input bit r);
    bit rdy, acc, o;
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = 8'(d);
    bus.in_clr    = c;
    bus.out_ready = r;
    @(negedge clk);
    rdy = !m_ov || r;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_ov});
    chk("of_sticky", {63'd0, bus.of_sticky}, {63'd0, m_sticky});
    chk("of_count", {56'd0, bus.of_count}, m_count);
    acc = v && rdy;
    if (acc) begin
      if (c) begin
        m_acc = d; o = 0; m_sticky = 0; m_count = 0;
      end else begin
        m_acc = add_result(m_acc, d, o);
        if (o) begin
          m_sticky = 1;
          if (m_count < 255) m_count++;
        end
      end
      e.acc = m_acc; e.pulse = o;
      sb.push_back(e);
      m_ov = 1;
    end else begin
      if (c) begin
        m_acc = 0; m_sticky = 0; m_count = 0;
      end
      if (r) m_ov = 0;
    end
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_acc_out", {56'd0, bus.acc_out}, 0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 0);
    chk("rst_of_pulse", {63'd0, bus.of_pulse}, 0);
    chk("rst_of_sticky", {63'd0, bus.of_sticky}, 0);
    chk("rst_of_count", {56'd0, bus.of_count}, 0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 1);
    bus.in_valid = 0; bus.in_clr = 0; bus.out_ready = 0; bus.in_data = '0;
    sb.delete();
    m_acc = 0; m_ov = 0; m_sticky = 0; m_count = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every presented result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {63'd0, bus.out_valid}, 0);
      end else if (bus.out_ready) begin
        chk("acc_out", $signed(bus.acc_out), sb[0].acc);
        chk("of_pulse", {63'd0, bus.of_pulse}, {63'd0, sb[0].pulse});
        void'(sb.pop_front());
      end else begin
        chk("acc_out_hold", $signed(bus.acc_out), sb[0].acc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

`ifdef OVF_ACCUM_SAT_EN
  localparam int EXP_POS = 127;
  localparam int EXP_NEG = -128;
`else
  localparam int EXP_POS = -106;
  localparam int EXP_NEG = 106;
`endif

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.in_clr = 0; bus.out_ready = 0;
    #12;
    chk("reset_acc_out", {56'd0, bus.acc_out}, 0);
    chk("reset_out_valid", {63'd0, bus.out_valid}, 0);
    chk("reset_of_count", {56'd0, bus.of_count}, 0);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 1);
    #11;
    rst_n = 1'b1;

    // Basic accumulation.
    step(1, 10, 0, 1);
    step(1, 20, 0, 1);
    step(1, -5, 0, 1);
    step(0, 0, 0, 1);

    // Positive overflow: acc=100, add 50.
    step(1, 100, 1, 1);
    step(1, 50, 0, 1);
    step(0, 0, 0, 0);
    chk("pos_ovf_acc", $signed(bus.acc_out), EXP_POS);
    chk("pos_ovf_pulse", {63'd0, bus.of_pulse}, 1);
    step(0, 0, 0, 1);

    // Negative overflow: acc=-100, add -50.
    step(1, -100, 1, 1);
    step(1, -50, 0, 1);
    step(0, 0, 0, 0);
    chk("neg_ovf_acc", $signed(bus.acc_out), EXP_NEG);
    chk("neg_ovf_pulse", {63'd0, bus.of_pulse}, 1);
    step(0, 0, 0, 1);

    // Backpressure: hold for 3 cycles, then accept in the releasing cycle.
    step(1, 1, 0, 0);
    repeat (3) step(1, 9, 0, 0);
    step(1, 9, 0, 1);
    step(0, 0, 0, 1);

    // Clear with acceptance after overflows.
    step(1, 100, 0, 1);
    step(1, 100, 0, 1);
    step(1, 7, 1, 1);
    step(0, 0, 0, 1);

    // Forced overflows until the counter saturates.
    step(1, 1, 1, 1);
    for (int i = 0; i < 320; i++) begin
      step(1, (m_acc >= 0) ? 127 : -128, 0, 1);
    end
    step(0, 0, 0, 1);
    chk("cnt_saturated", {56'd0, bus.of_count}, 255);
    step(1, 5, 0, 0);
    reset_mid_cycle();
    step(0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 255) - 128,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    repeat (3) step(0, 0, 0, 1);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ovf_accum.md
OVF_ACCUM -- requirements
Module: ovf_accum

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: two's-complement data and accumulator width; legal range 4..64.
- REQ-002 SHALL have parameter CNT_W, default 8: overflow event counter width.
- REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
- REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
- REQ-005 SHALL have port in_valid  input  1: in_data is valid this cycle.
- REQ-006 SHALL have port in_ready  output  1: block can accept in_data this cycle.
- REQ-007 SHALL have port in_data  input  WIDTH: signed addend.
- REQ-008 SHALL have port in_clr  input  1: clear the accumulator.
- REQ-009 SHALL have port out_valid  output  1: acc_out holds an unconsumed result.
- REQ-010 SHALL have port out_ready  input  1: consumer accepts acc_out.
- REQ-011 SHALL have port acc_out  output  WIDTH: signed accumulator value.
- REQ-012 SHALL have port of_pulse  output  1: overflow occurred on the result now in acc_out.
- REQ-013 SHALL have port of_sticky  output  1: at least one overflow since the last reset or clear.
- REQ-014 SHALL have port of_count  output  CNT_W: number of overflow events.

Function
- REQ-015 SHALL accept an input when in_valid and in_ready are both high in the same cycle.
- REQ-016 SHALL drive in_ready = !out_valid | out_ready, giving one result register with pass-through backpressure.
- REQ-017 SHALL compute sum = acc + in_data in WIDTH+1 bits on acceptance; result registered next edge, so latency is 1 cycle.
- REQ-018 SHALL detect overflow as carry-into-MSB XOR carry-out-of-MSB, i.e. both operands share a sign that differs from the sign of sum[WIDTH-1].
- REQ-019 SHALL, on acceptance, set out_valid=1, acc_out=acc, of_pulse=overflow flag.
- REQ-020 SHALL clear out_valid on out_ready when no new acceptance occurs in the same cycle.
- REQ-021 SHALL keep acc_out, out_valid and of_pulse stable while out_valid=1 and out_ready=0.
- REQ-022 SHALL increment of_count by 1 per overflow; of_count saturates at all-ones and does not wrap.
- REQ-023 SHALL, on in_clr without acceptance, zero acc, of_sticky and of_count; out_valid is unaffected.
- REQ-024 SHALL, on in_clr with acceptance in the same cycle, load acc=in_data, report no overflow, zero of_sticky and of_count, and set out_valid=1.
- REQ-025 SHALL ignore in_data while in_valid=0 and accumulate nothing.

Reset
- REQ-026 SHALL, while rst_n=0, asynchronously force acc=0, acc_out=0, out_valid=0, of_pulse=0, of_sticky=0, of_count=0; in_ready=1 after reset.
- REQ-027 SHALL, when reset is asserted mid-transaction, discard the pending result with no output pulse.

Configuration
- REQ-028 SHALL provide macro OVF_ACCUM_SAT_EN.
- REQ-029 SHALL, when OVF_ACCUM_SAT_EN is defined, clamp acc on overflow to +max (0111..1) for positive overflow and -min (1000..0) for negative overflow.
- REQ-030 SHALL, when OVF_ACCUM_SAT_EN is undefined, let acc wrap modulo 2^WIDTH.
- REQ-031 SHALL detect, flag and count overflow identically in both builds.

Structure
- REQ-032 SHALL place overflow-direction enum (NONE/POS/NEG) and saturation-limit constant functions of WIDTH in package ovf_accum_pkg.
- REQ-033 SHALL implement the adder and overflow detect as one combinational sub-module ovf_add (a, b -> sum, ovf_dir); all state lives in ovf_accum.

Verification (WIDTH=8, CNT_W=8)
- REQ-034 SHALL cover: reset, then accept 10, 20, -5 with out_ready=1 -> acc_out 10, 30, 25 on successive cycles, of_pulse=0.
- REQ-035 SHALL cover: acc=100, accept 50 -> of_pulse=1, of_sticky=1, of_count=1; acc_out=127 (SAT_EN) or -106 (wrap).
- REQ-036 SHALL cover: acc=-100, accept -50 -> of_pulse=1; acc_out=-128 (SAT_EN) or 106 (wrap).
- REQ-037 SHALL cover: out_ready=0 for 3 cycles after a result -> in_ready=0, acc_out held; out_ready=1 -> next input accepted same cycle.
- REQ-038 SHALL cover: in_clr with in_valid=1, in_data=7 after overflows -> acc_out=7, of_sticky=0, of_count=0.
- REQ-039 SHALL cover: 300 forced overflows -> of_count stops at 255; rst_n pulsed mid-stream -> all outputs 0 asynchronously.
